alu_exec_unit: RTL and testbench

//  Execute-stage ALU. It consumes the 4-bit alu_ctrl code from ALU control

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_exec_unit_if.sv | 17 +
 rtl/alu_mul_seq.sv | 39 +++
 rtl/alu_exec_unit.sv | 49 ++++
 tb/tb_alu_exec_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operation codes and FSM states shared by the ALU control and execute units
package alu_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_if: operand/result valid-ready bundle between the front end and the execute ALU
interface alu_exec_if #(parameter int WIDTH = 32) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    modport master (output in_valid, alu_ctrl, op_a, op_b, out_ready,
                    input in_ready, out_valid, result, zero, busy);
    modport slave (input in_valid, alu_ctrl, op_a, op_b, out_ready,
                   output in_ready, out_valid, result, zero, busy);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle, done on the last step
module alu_mul_seq #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    always_comb begin
        product = acc_q + (b_q[0] ? a_q : '0);
        done    = run_q && cnt_q == CW'(WIDTH - 1);
        run_d   = start || (run_q && !done);
        cnt_d   = start ? '0 : run_q ? cnt_q + CW'(1) : cnt_q;
        a_d     = start ? a : run_q ? a_q << 1 : a_q;
        b_d     = start ? b : run_q ? b_q >> 1 : b_q;
        acc_d   = start ? '0 : run_q ? product : acc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result/zero, valid-ready on both sides, sequential MUL
module alu_exec_unit import alu_pkg::*; #(parameter int WIDTH = 32) (
    input logic       clk,
    input logic       rst,
    alu_exec_if.slave bus
);
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d, zero_q, zero_d;
    logic [WIDTH-1:0] result_q, result_d, simple, product;
    logic             accept, is_mul, mul_done, load_simple, load_mul;
    assign bus.in_ready  = state_q == S_IDLE && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = state_q == S_MUL;
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .rst(rst), .start(accept && is_mul),
        .a(bus.op_a), .b(bus.op_b), .done(mul_done), .product(product)
    );
    always_comb begin
        is_mul      = bus.alu_ctrl == ALU_MUL;
        accept      = bus.in_valid && bus.in_ready;
        simple      = bus.alu_ctrl == ALU_ADD ? bus.op_a + bus.op_b :
                      bus.alu_ctrl == ALU_SUB ? bus.op_a - bus.op_b :
                      bus.alu_ctrl == ALU_AND ? bus.op_a & bus.op_b :
                      bus.alu_ctrl == ALU_OR  ? bus.op_a | bus.op_b :
                      bus.alu_ctrl == ALU_SLT ? WIDTH'($signed(bus.op_a) < $signed(bus.op_b)) :
                      '0;
        load_simple = accept && !is_mul;
        load_mul    = state_q == S_MUL && mul_done;
        result_d    = load_simple ? simple : load_mul ? product : result_q;
        zero_d      = (load_simple || load_mul) ? result_d == '0 : zero_q;
        out_valid_d = load_simple || load_mul || (out_valid_q && !bus.out_ready);
        state_d     = accept && is_mul ? S_MUL : load_mul ? S_IDLE : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed checks of alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [3:0] codes [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111, 4'b0011};
    always #5 clk = ~clk;
    alu_exec_if #(.WIDTH(32)) bus ();
    alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: return a * b;
            default: return 32'd0;
        endcase
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drain;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL accept_timeout ctrl=%b in_ready stayed low", c); end
    endtask
    task automatic check_simple(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        exp = ref_op(c, a, b);
        send(c, a, b);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", name, bus.out_valid); end
        checks++;
        if (bus.result !== exp) begin errors++; $display("FAIL %s_result got %h exp %h", name, bus.result, exp); end
        checks++;
        if (bus.zero !== (exp == 0)) begin errors++; $display("FAIL %s_zero got %b exp %b", name, bus.zero, exp == 0); end
    endtask
    task automatic test_reset;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_ctrl  = 4'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        checks++;
        if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", bus.zero); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask
    task automatic test_simple;
        drain();
        check_simple("add_5_7", 4'b0010, 32'd5, 32'd7);
        check_simple("sub_9_9", 4'b0110, 32'd9, 32'd9);
        check_simple("slt_m1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1);
        check_simple("slt_1_m1", 4'b0111, 32'd1, 32'hFFFF_FFFF);
        check_simple("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1);
        check_simple("and_rand", 4'b0000, 32'hF0F0_1234, 32'h0F0F_FFFF);
        check_simple("or_zero", 4'b0001, 32'd0, 32'd0);
        check_simple("unknown_1111", 4'b1111, $urandom, $urandom);
        for (int i = 0; i < 12; i++)
            check_simple("rand_simple", codes[$urandom_range(0, 6)], $urandom, $urandom);
    endtask
    task automatic mul_case(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int n = 0;
        bit bad = 1'b0;
        exp = ref_op(4'b1000, a, b);
        drain();
        send(4'b1000, a, b);
        while (bus.out_valid !== 1'b1 && n < 100) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin errors++; $display("FAIL mul_latency got %0d exp 32", n); end
        checks++;
        if (bad) begin errors++; $display("FAIL mul_busy_stall busy/in_ready wrong during MUL of %h*%h", a, b); end
        checks++;
        if (bus.result !== exp) begin errors++; $display("FAIL mul_result %h*%h got %h exp %h", a, b, bus.result, exp); end
        checks++;
        if (bus.zero !== (exp == 0)) begin errors++; $display("FAIL mul_zero got %b exp %b", bus.zero, exp == 0); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end got %b exp 0", bus.busy); end
    endtask
    task automatic test_mul;
        mul_case(32'd6, 32'd7);
        mul_case(32'h0001_0000, 32'h0001_0000);
        mul_case(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mul_case(32'd0, $urandom);
        for (int i = 0; i < 4; i++) mul_case($urandom, $urandom);
    endtask
    task automatic test_backpressure;
        drain();
        bus.out_ready = 1'b0;
        send(4'b0010, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd7 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d valid=%b result=%h in_ready=%b exp 1/7/0", i, bus.out_valid, bus.result, bus.in_ready);
            end
            tick();
        end
        bus.alu_ctrl  = 4'b0010;
        bus.op_a      = 32'd10;
        bus.op_b      = 32'd20;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'd30) begin
            errors++;
            $display("FAIL pop_and_accept valid=%b result=%h exp 1/%h", bus.out_valid, bus.result, 32'd30);
        end
    endtask
    task automatic test_back_to_back;
        bit pending = 1'b0;
        logic [31:0] exp = '0;
        logic [31:0] a, b;
        logic [3:0] c;
        drain();
        for (int i = 0; i < 80; i++) begin
            c = codes[$urandom_range(0, 6)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            bus.alu_ctrl  = c;
            bus.op_a      = a;
            bus.op_b      = b;
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.out_ready = $urandom_range(0, 2) != 0;
            #1;
            checks++;
            if (bus.in_ready !== (!pending || bus.out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready cycle%0d got %b exp %b", i, bus.in_ready, !pending || bus.out_ready);
            end
            checks++;
            if (bus.out_valid !== pending) begin errors++; $display("FAIL b2b_valid cycle%0d got %b exp %b", i, bus.out_valid, pending); end
            if (pending) begin
                checks++;
                if (bus.result !== exp || bus.zero !== (exp == 0)) begin
                    errors++;
                    $display("FAIL b2b_result cycle%0d got %h/%b exp %h/%b", i, bus.result, bus.zero, exp, exp == 0);
                end
            end
            if (bus.in_valid && (!pending || bus.out_ready)) begin
                pending = 1'b1;
                exp = ref_op(c, a, b);
            end else if (bus.out_ready) pending = 1'b0;
            tick();
        end
        drain();
    endtask
    task automatic test_reset_mid_mul;
        bit seen = 1'b0;
        drain();
        send(4'b1000, 32'd123, 32'd456);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midmul_reset busy=%b valid=%b exp 0/0", bus.busy, bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midmul_in_ready got %b exp 1", bus.in_ready); end
        checks++;
        if (bus.result !== 32'd0) begin errors++; $display("FAIL midmul_result got %h exp 0", bus.result); end
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midmul_ghost out_valid pulsed got 1 exp 0"); end
        check_simple("post_reset_unknown", 4'b1111, 32'd77, 32'd88);
        check_simple("post_reset_add", 4'b0010, 32'd100, 32'hFFFF_FF9C);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_simple();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
